// File: rtl/esfa_job_scheduler.sv
// esfa_job_scheduler: round-robin arbiter that shares one ESFADesign core
// among NREQ requesters. It accepts one descriptor, starts the core, waits
// for done or a watchdog timeout, then returns the result to the granted
// requester. Every output is a register, so no input reaches an output
// through combinational logic.
module esfa_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int RW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [RW-1:0]           resp_data,
  output logic                    resp_timeout,
  output logic                    core_start,
  output logic [DW-1:0]           core_data,
  input  logic                    core_done,
  input  logic [RW-1:0]           core_result,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                   state;
  logic [GW-1:0]            rr_ptr;
  logic [CW-1:0]            wd_cnt;
  logic [DW-1:0]            desc_q;
  logic [RW-1:0]            result_q;
  logic                     timeout_q;

  // Per-requester view of the flat descriptor bus.
  logic [NREQ-1:0][DW-1:0]  req_lane;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_lane[i] = req_data[i*DW +: DW];
  end

  // Core sees the captured descriptor; it stays put until the next ACCEPT.
  assign core_data    = desc_q;
  assign resp_data    = result_q;
  assign resp_timeout = timeout_q;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  // Scanning from the far end down lets the nearest candidate win last.
  logic          pick_found;
  logic [GW-1:0] pick_id;
  logic [GW:0]   scan_sum;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (scan_sum >= (GW+1)'(NREQ))
        scan_sum = scan_sum - (GW+1)'(NREQ);
      if (req_valid[scan_sum[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_sum[GW-1:0];
      end
    end
  end

  // Job FSM with registered pulse outputs; core_done only matters in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      wd_cnt     <= '0;
      desc_q     <= '0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_id;
            req_ready <= onehot(pick_id);
            busy      <= 1'b1;
            state     <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          desc_q     <= req_lane[grant_id];
          req_ready  <= '0;
          core_start <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          core_start <= 1'b0;
          wd_cnt     <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the last watchdog cycle still counts as a completion.
          if (core_done) begin
            result_q   <= core_result;
            timeout_q  <= 1'b0;
            resp_valid <= onehot(grant_id);
            state      <= S_RESP;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            result_q   <= '0;
            timeout_q  <= 1'b1;
            resp_valid <= onehot(grant_id);
            state      <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        S_RESP: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          rr_ptr     <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
          state      <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= '0;
          resp_valid <= '0;
          core_start <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_job_scheduler.sv
// Directed bench for esfa_job_scheduler (NREQ=4, TIMEOUT=8).
module tb_esfa_job_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int RW   = 16;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [RW-1:0]     resp_data;
  logic              resp_timeout;
  logic              core_start;
  logic [DW-1:0]     core_data;
  logic              core_done;
  logic [RW-1:0]     core_result;
  logic              busy;
  logic [1:0]        grant_id;

  logic [DW-1:0]     lane_data [NREQ];
  assign req_data = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  esfa_job_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Pulse counters for the fairness run, sampled mid-cycle.
  bit cnt_en = 1'b0;
  int rdy_cnt  [NREQ] = '{default: 0};
  int resp_cnt [NREQ] = '{default: 0};
  always @(negedge clk) begin
    if (cnt_en) begin
      for (int i = 0; i < NREQ; i++) begin
        rdy_cnt[i]  += int'(req_ready[i]);
        resp_cnt[i] += int'(resp_valid[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the request is already driven (cycle 0).
  // Done is driven in cycle 3+w; the response is checked one cycle later.
  task automatic run_job(input int gid, input int w, input logic [RW-1:0] res,
                         input bit release_req);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[gid] = 1'b1;
    step();
    chk("ready", 32'(req_ready), 32'(oh));
    chk("grant", 32'(grant_id), 32'(gid));
    if (release_req) req_valid[gid] = 1'b0;
    step();
    chk("start", 32'(core_start), 32'd1);
    chk("cdata", core_data, lane_data[gid]);
    chk("ready_w", 32'(req_ready), 32'd0);
    step();
    chk("start_w", 32'(core_start), 32'd0);
    repeat (w) step();
    core_done   = 1'b1;
    core_result = res;
    step();
    core_done = 1'b0;
    chk("rvalid", 32'(resp_valid), 32'(oh));
    chk("rdata", 32'(resp_data), 32'(res));
    chk("rto", 32'(resp_timeout), 32'd0);
    step();
    chk("rvalid_w", 32'(resp_valid), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    req_valid = '0;
    core_done = 1'b0;
    core_result = '0;
    for (int i = 0; i < NREQ; i++) lane_data[i] = 32'hA000_0000 + 32'(i);
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_cdata", core_data, 32'd0);

    // Single job, requester 2, done 3 cycles after start
    lane_data[2] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    run_job(2, 2, 16'h1234, 1'b1);

    // Round-robin fairness from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    lane_data[2] = 32'hA000_0002;
    req_valid = 4'b1111;
    cnt_en = 1'b1;
    for (int j = 0; j < 8; j++) run_job(j % 4, j % 3, 16'h0100 + 16'(j), 1'b0);
    req_valid = '0;
    step();
    cnt_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("rr_rdy%0d", i), 32'(rdy_cnt[i]), 32'd2);
      chk($sformatf("rr_resp%0d", i), 32'(resp_cnt[i]), 32'd2);
    end

    // Timeout: requester 0 (rr_ptr wrapped to 0), core never responds
    req_valid = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) req_valid = '0;
    end
    chk("to_early", 32'(resp_valid), 32'd0);
    step();
    chk("to_rvalid", 32'(resp_valid), 32'b0001);
    chk("to_flag", 32'(resp_timeout), 32'd1);
    chk("to_rdata", 32'(resp_data), 32'd0);
    step();
    chk("to_idle", 32'(busy), 32'd0);

    // Done in the last watchdog cycle wins, requester 1
    req_valid = 4'b0010;
    run_job(1, 7, 16'hBEEF, 1'b1);

    // Stray done in plain IDLE
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("stray_idle", {31'd0, busy} | 32'(resp_valid), 32'd0);

    // Stray done with request in IDLE and in ISSUE, requester 2
    req_valid = 4'b0100;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("stray_rdy", 32'(req_ready), 32'b0100);
    req_valid = '0;
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    seen = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      if (resp_valid != '0 || !busy) seen = 1'b1;
      if (c < 8) step();
    end
    chk("stray_wait", 32'(seen), 32'd0);
    core_done = 1'b1;
    core_result = 16'h5A5A;
    step();
    core_done = 1'b0;
    chk("stray_rv", 32'(resp_valid), 32'b0100);
    chk("stray_rd", 32'(resp_data), 32'h5A5A);
    step();

    // Reset during WAIT, requester 3
    req_valid = 4'b1000;
    step();
    chk("mid_rdy", 32'(req_ready), 32'b1000);
    req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_outs", 32'(req_ready) | 32'(resp_valid) | {31'd0, core_start} |
        {31'd0, resp_timeout} | 32'(resp_data), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_gid", 32'(grant_id), 32'd0);
    req_valid = 4'b1010;
    run_job(1, 0, 16'h0011, 1'b1);
    run_job(3, 1, 16'h0033, 1'b1);
    repeat (3) step();
    chk("final_idle", {31'd0, busy} | 32'(req_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
